window_trap_ctrl: RTL and testbench
===================================

WINDOW_TRAP_CTRL -- requirements
Module: window_trap_ctrl

Interface
REQ-001 Parameter NWINDOWS, default 3: number of implemented register windows (2..32).
REQ-002 Parameter WORDS, default 16: registers moved per window (r16..r31, locals and ins).
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 windows_overflow  in  1  overflow trap pending from the register window.
REQ-006 windows_underflow  in  1  underflow trap pending from the register window.
REQ-007 cwp  in  5  current window pointer from the register window.
REQ-008 save_base  in  32  byte address of the spill/fill save area, sampled at sequence start.
REQ-009 reg_rdata  in  32  register window r1 read data.
REQ-010 mem_ack  in  1  memory transfer complete; mem_rdata valid when mem_we=0.
REQ-011 mem_rdata  in  32  memory read data.
REQ-012 busy  out  1  sequence in progress; pipeline must stall.
REQ-013 cwp_wr / cwp_out  out  1/5  CWP write strobe and value.
REQ-014 wim_wr / wim_out  out  1/32  WIM write strobe and value.
REQ-015 reg_sel  out  5  register select, driven to both r1 and rd.
REQ-016 reg_wr / reg_wdata  out  1/32  register write strobe and data.
REQ-017 mem_req / mem_we / mem_addr / mem_wdata  out  1/1/32/32  memory request.
REQ-018 overflow_handled / underflow_handled  out  1/1  one-cycle completion pulses.

Function
REQ-019 States: IDLE, SET_CWP, SP_RD, SP_WR, FL_RD, FL_WR, RST_CWP, WIM_UPD, DONE.
REQ-020 IDLE: overflow=1 starts a spill; else underflow=1 starts a fill; overflow wins when both are set.
REQ-021 On start: latch orig=cwp and base=save_base; idx=0; W=(cwp-1) mod NWINDOWS for spill, (cwp+1) mod NWINDOWS for fill; go to SET_CWP.
REQ-022 SET_CWP (1 cycle): cwp_wr=1, cwp_out=W; next state is SP_RD (spill) or FL_RD (fill).
REQ-023 SP_RD (1 cycle): reg_sel=16+idx; latch reg_rdata into mem_wdata; go to SP_WR.
REQ-024 SP_WR: mem_req=1, mem_we=1, mem_addr=base+4*idx; hold until mem_ack; on ack, idx=WORDS-1 goes to RST_CWP, else idx+1 goes to SP_RD.
REQ-025 FL_RD: mem_req=1, mem_we=0, mem_addr=base+4*idx; hold until mem_ack; on ack, latch mem_rdata and go to FL_WR.
REQ-026 FL_WR (1 cycle): reg_wr=1, reg_sel=16+idx, reg_wdata=latched data; idx=WORDS-1 goes to RST_CWP, else idx+1 goes to FL_RD.
REQ-027 mem_addr, mem_we and mem_wdata stay stable while mem_req=1; mem_ack with mem_req=0 is ignored.
REQ-028 RST_CWP (1 cycle): cwp_wr=1, cwp_out=orig.
REQ-029 WIM_UPD (1 cycle): wim_wr=1; wim_out one-hot at (W-1) mod NWINDOWS for spill, (W+1) mod NWINDOWS for fill; bits >= NWINDOWS are 0.
REQ-030 DONE (1 cycle): pulse overflow_handled (spill) or underflow_handled (fill); go to IDLE.
REQ-031 A trap still asserted in the cycle after DONE starts a new sequence.
REQ-032 busy=1 in every state except IDLE.
REQ-033 At most one of cwp_wr, wim_wr, reg_wr is high in any cycle; all strobes are 0 in IDLE.
REQ-034 Modulo arithmetic wraps: cwp=0 spill gives W=NWINDOWS-1; cwp=NWINDOWS-1 fill gives W=0; addresses are 32-bit and wrap silently.
REQ-035 With mem_ack high in the first request cycle, trap-to-handled latency from the IDLE detect edge is 2*WORDS+4 cycles (36 at default).
REQ-036 Traps arriving during busy=1 are ignored until IDLE.

Reset
REQ-037 rst low forces IDLE immediately, including mid-sequence; no restore of CWP or WIM is performed.
REQ-038 Reset values: all outputs 0; idx, orig, base, W and data latch 0.

Configuration
REQ-039 Macro WINCTRL_FILL_EN defined: the full fill sequence is present.
REQ-040 Macro WINCTRL_FILL_EN undefined: FL_RD/FL_WR are removed; underflow goes to SET_CWP, then RST_CWP, WIM_UPD, DONE with no memory or register traffic (latency 4).

Verification
REQ-041 NWINDOWS=3, cwp=0, overflow=1, save_base=0x1000, ack immediate -> cwp_out 2 then 0; 16 writes to 0x1000..0x103C with data from r16..r31; wim_out=0x2; overflow_handled at cycle 36.
REQ-042 cwp=2, underflow=1, base=0x2000, 3 wait cycles per ack -> CWP set to 0; 16 reg writes r16..r31 with memory data; wim_out=0x2; underflow_handled once.
REQ-043 overflow=1 and underflow=1 in the same cycle -> spill runs first, then fill starts the cycle after DONE.
REQ-044 rst low during SP_WR with idx=7 -> next cycle all outputs 0, state IDLE, no handled pulse.
REQ-045 Spurious mem_ack in IDLE and SP_RD -> no state or idx change.
REQ-046 WINCTRL_FILL_EN undefined, underflow=1 -> no mem_req; underflow_handled 4 cycles after detect.

Source files
------------

// File: rtl/window_trap_ctrl.sv
// Register-window overflow/underflow handler: spills or fills one window through memory, then fixes up CWP and WIM.
// Build option: define WINCTRL_FILL_EN to include the memory fill sequence; otherwise underflow only moves CWP/WIM.
module window_trap_ctrl #(
    parameter int NWINDOWS = 3,
    parameter int WORDS    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        windows_overflow,
    input  logic        windows_underflow,
    input  logic [4:0]  cwp,
    input  logic [31:0] save_base,
    input  logic [31:0] reg_rdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        cwp_wr,
    output logic [4:0]  cwp_out,
    output logic        wim_wr,
    output logic [31:0] wim_out,
    output logic [4:0]  reg_sel,
    output logic        reg_wr,
    output logic [31:0] reg_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        overflow_handled,
    output logic        underflow_handled
);

    localparam int            IW       = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [4:0]    W_MAX    = 5'(NWINDOWS - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WORDS - 1);

    typedef enum logic [3:0] {
        IDLE,
        SET_CWP,
        SP_RD,
        SP_WR,
`ifdef WINCTRL_FILL_EN
        FL_RD,
        FL_WR,
`endif
        RST_CWP,
        WIM_UPD,
        DONE
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [IW-1:0]   idx_reg;
    logic [4:0]      orig_reg;
    logic [4:0]      w_reg;
    logic [31:0]     base_reg;
    logic [31:0]     data_reg;
    logic            fill_reg;
    logic            last_word;
    logic [31:0]     word_addr;
    logic [4:0]      wim_pos;

    function automatic logic [4:0] wrap_dec(input logic [4:0] v);
        return (v == 5'd0) ? W_MAX : v - 5'd1;
    endfunction

    function automatic logic [4:0] wrap_inc(input logic [4:0] v);
        return (v >= W_MAX) ? 5'd0 : v + 5'd1;
    endfunction

    assign last_word = (idx_reg == IDX_LAST);
    assign word_addr = base_reg + (32'(idx_reg) << 2);
    // Invalid window is one beyond the target window, in the direction of travel.
    assign wim_pos   = fill_reg ? wrap_inc(w_reg) : wrap_dec(w_reg);

`ifndef WINCTRL_FILL_EN
    logic unused_mem_rdata;
    assign unused_mem_rdata = ^mem_rdata;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (windows_overflow || windows_underflow) begin
                    state_next = SET_CWP;
                end
            end
            SET_CWP: begin
`ifdef WINCTRL_FILL_EN
                state_next = fill_reg ? FL_RD : SP_RD;
`else
                state_next = fill_reg ? RST_CWP : SP_RD;
`endif
            end
            SP_RD: state_next = SP_WR;
            SP_WR: begin
                if (mem_ack) begin
                    state_next = last_word ? RST_CWP : SP_RD;
                end
            end
`ifdef WINCTRL_FILL_EN
            FL_RD: begin
                if (mem_ack) begin
                    state_next = FL_WR;
                end
            end
            FL_WR: state_next = last_word ? RST_CWP : FL_RD;
`endif
            RST_CWP: state_next = WIM_UPD;
            WIM_UPD: state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy              = (state_reg != IDLE);
        cwp_wr            = 1'b0;
        cwp_out           = 5'd0;
        wim_wr            = 1'b0;
        reg_sel           = 5'd0;
        reg_wr            = 1'b0;
        reg_wdata         = 32'd0;
        mem_req           = 1'b0;
        mem_we            = 1'b0;
        mem_addr          = 32'd0;
        mem_wdata         = 32'd0;
        overflow_handled  = 1'b0;
        underflow_handled = 1'b0;
        case (state_reg)
            SET_CWP: begin
                cwp_wr  = 1'b1;
                cwp_out = w_reg;
            end
            SP_RD: reg_sel = 5'd16 + 5'(idx_reg);
            SP_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = word_addr;
                mem_wdata = data_reg;
            end
`ifdef WINCTRL_FILL_EN
            FL_RD: begin
                mem_req  = 1'b1;
                mem_addr = word_addr;
            end
            FL_WR: begin
                reg_wr    = 1'b1;
                reg_sel   = 5'd16 + 5'(idx_reg);
                reg_wdata = data_reg;
            end
`endif
            RST_CWP: begin
                cwp_wr  = 1'b1;
                cwp_out = orig_reg;
            end
            WIM_UPD: wim_wr = 1'b1;
            DONE: begin
                overflow_handled  = ~fill_reg;
                underflow_handled = fill_reg;
            end
            default: ;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_wim
            if (gi < NWINDOWS) begin : g_impl
                assign wim_out[gi] = wim_wr && (wim_pos == 5'(gi));
            end else begin : g_unimpl
                assign wim_out[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_reg  <= '0;
            orig_reg <= 5'd0;
            w_reg    <= 5'd0;
            base_reg <= 32'd0;
            data_reg <= 32'd0;
            fill_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (windows_overflow || windows_underflow) begin
                        orig_reg <= cwp;
                        base_reg <= save_base;
                        idx_reg  <= '0;
                        fill_reg <= ~windows_overflow;
                        w_reg    <= windows_overflow ? wrap_dec(cwp) : wrap_inc(cwp);
                    end
                end
                SP_RD: data_reg <= reg_rdata;
                SP_WR: begin
                    if (mem_ack && !last_word) begin
                        idx_reg <= idx_reg + IW'(1);
                    end
                end
`ifdef WINCTRL_FILL_EN
                FL_RD: begin
                    if (mem_ack) begin
                        data_reg <= mem_rdata;
                    end
                end
                FL_WR: begin
                    if (!last_word) begin
                        idx_reg <= idx_reg + IW'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_window_trap_ctrl.sv
// Bench for window_trap_ctrl: directed table, randomized traps against a transaction-level model, and corner sequences.
module tb_window_trap_ctrl;

    localparam int N     = 3;
    localparam int WORDS = 16;
`ifdef WINCTRL_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        windows_overflow;
    logic        windows_underflow;
    logic [4:0]  cwp;
    logic [31:0] save_base;
    logic [31:0] reg_rdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        cwp_wr;
    logic [4:0]  cwp_out;
    logic        wim_wr;
    logic [31:0] wim_out;
    logic [4:0]  reg_sel;
    logic        reg_wr;
    logic [31:0] reg_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        overflow_handled;
    logic        underflow_handled;

    window_trap_ctrl #(.NWINDOWS(N), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst),
        .windows_overflow(windows_overflow), .windows_underflow(windows_underflow),
        .cwp(cwp), .save_base(save_base), .reg_rdata(reg_rdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy),
        .cwp_wr(cwp_wr), .cwp_out(cwp_out), .wim_wr(wim_wr), .wim_out(wim_out),
        .reg_sel(reg_sel), .reg_wr(reg_wr), .reg_wdata(reg_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .overflow_handled(overflow_handled), .underflow_handled(underflow_handled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic any_out;
    assign any_out = busy | cwp_wr | (|cwp_out) | wim_wr | (|wim_out) | (|reg_sel) | reg_wr |
                     (|reg_wdata) | mem_req | mem_we | (|mem_addr) | (|mem_wdata) |
                     overflow_handled | underflow_handled;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Environment: register file / memory responder and event monitor
    int          waits = 0;
    bit          spur = 1'b0;
    logic [31:0] salt = 32'd0;
    int          cyc = 0;
    int          wait_cnt = 0;
    int          req_cycles = 0;
    int          viol_excl = 0, viol_idle = 0, viol_stab = 0;
    logic [4:0]  cwp_q[$];
    logic [31:0] wim_q[$];
    logic [36:0] regw_q[$];
    logic [63:0] memw_q[$];
    logic [31:0] memr_q[$];
    int          h_cyc_q[$];
    bit          h_kind_q[$];
    int          rise_q[$];

    function automatic logic [31:0] reg_val(input logic [4:0] sel);
        return (32'(sel) * 32'h0101_0101) ^ salt;
    endfunction

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ ~salt;
    endfunction

    initial begin
        logic        prev_busy, prev_pend, prev_we;
        logic [31:0] prev_addr, prev_wdata;
        prev_busy = 1'b0; prev_pend = 1'b0; prev_we = 1'b0;
        prev_addr = 32'd0; prev_wdata = 32'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0; reg_rdata = 32'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (busy && !prev_busy) rise_q.push_back(cyc);
            if (overflow_handled) begin h_cyc_q.push_back(cyc); h_kind_q.push_back(1'b1); end
            if (underflow_handled) begin h_cyc_q.push_back(cyc); h_kind_q.push_back(1'b0); end
            if (cwp_wr) cwp_q.push_back(cwp_out);
            if (wim_wr) wim_q.push_back(wim_out);
            if (reg_wr) regw_q.push_back({reg_sel, reg_wdata});
            if (int'(cwp_wr) + int'(wim_wr) + int'(reg_wr) > 1) viol_excl++;
            if (!busy && (cwp_wr | wim_wr | reg_wr | mem_req | overflow_handled | underflow_handled))
                viol_idle++;
            if (prev_pend && mem_req &&
                (mem_addr !== prev_addr || mem_we !== prev_we || mem_wdata !== prev_wdata))
                viol_stab++;
            reg_rdata = reg_val(reg_sel);
            mem_rdata = mem_val(mem_addr);
            if (mem_req) begin
                req_cycles++;
                if (wait_cnt >= waits) begin mem_ack = 1'b1; wait_cnt = 0; end
                else begin mem_ack = 1'b0; wait_cnt++; end
            end else begin
                mem_ack  = spur;
                wait_cnt = 0;
            end
            if (mem_req && mem_ack) begin
                if (mem_we) memw_q.push_back({mem_addr, mem_wdata});
                else        memr_q.push_back(mem_addr);
            end
            prev_busy  = busy;
            prev_pend  = mem_req && !mem_ack;
            prev_we    = mem_we;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
        end
    end

    task automatic clear_mon();
        cwp_q.delete(); wim_q.delete(); regw_q.delete(); memw_q.delete(); memr_q.delete();
        h_cyc_q.delete(); h_kind_q.delete(); rise_q.delete();
        req_cycles = 0;
    endtask

    function automatic int qsize(input int which);
        case (which)
            0:       return h_cyc_q.size();
            1:       return rise_q.size();
            default: return memw_q.size();
        endcase
    endfunction

    task automatic wait_q(input int which, input int n, input string name);
        int k = 0;
        while (qsize(which) < n && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk(name, qsize(which) >= n, 1);
    endtask

    task automatic run_trap(input bit ov, input bit un, input logic [4:0] c,
                            input logic [31:0] b, input int w, input bit sp);
        waits = w;
        salt  = $urandom;
        @(negedge clk);
        clear_mon();
        spur = sp;
        windows_overflow = ov; windows_underflow = un; cwp = c; save_base = b;
        @(negedge clk);
        windows_overflow = 1'b0; windows_underflow = 1'b0;
        cwp = 5'($urandom_range(0, N - 1)); save_base = $urandom;
        wait_q(0, 1, "handled_seen");
        repeat (3) @(negedge clk);
        spur = 1'b0;
    endtask

    // Transaction-level expectation for one completed trap.
    task automatic verify(input bit ov, input logic [4:0] c, input logic [31:0] b, input int w);
        int          ci, wexp, wpos, lat, n_w, n_f;
        bit          traffic;
        logic [31:0] a;
        ci      = int'(c);
        wexp    = ov ? (ci + N - 1) % N : (ci + 1) % N;
        wpos    = ov ? (wexp + N - 1) % N : (wexp + 1) % N;
        traffic = ov || FILL_EN;
        lat     = traffic ? 2 * WORDS + 4 + w * WORDS : 4;
        n_w     = ov ? WORDS : 0;
        n_f     = (!ov && FILL_EN) ? WORDS : 0;
        chk("handled_count", h_kind_q.size(), 1);
        chk("handled_kind", (h_kind_q.size() > 0) ? h_kind_q[0] : 1'bx, ov);
        chk("latency", (h_cyc_q.size() > 0 && rise_q.size() > 0) ? h_cyc_q[0] - rise_q[0] + 1 : -1, lat);
        chk("cwp_writes", cwp_q.size(), 2);
        chk("cwp_target", (cwp_q.size() > 0) ? cwp_q[0] : 5'bx, wexp);
        chk("cwp_restore", (cwp_q.size() > 1) ? cwp_q[1] : 5'bx, c);
        chk("wim_writes", wim_q.size(), 1);
        chk("wim_value", (wim_q.size() > 0) ? wim_q[0] : 32'bx, 32'd1 << wpos);
        chk("req_cycles", req_cycles, traffic ? WORDS * (w + 1) : 0);
        chk("memw_count", memw_q.size(), n_w);
        for (int i = 0; i < n_w && i < memw_q.size(); i++) begin
            a = b + 32'(4 * i);
            chk($sformatf("memw[%0d]", i), memw_q[i], {a, reg_val(5'(16 + i))});
        end
        chk("memr_count", memr_q.size(), n_f);
        chk("regw_count", regw_q.size(), n_f);
        for (int i = 0; i < n_f && i < memr_q.size() && i < regw_q.size(); i++) begin
            a = b + 32'(4 * i);
            chk($sformatf("memr[%0d]", i), memr_q[i], a);
            chk($sformatf("regw[%0d]", i), regw_q[i], {5'(16 + i), mem_val(a)});
        end
    endtask

    typedef struct {
        bit          ov;
        bit          un;
        logic [4:0]  cwp;
        logic [31:0] base;
        int          waits;
        logic [4:0]  exp_w;
        logic [31:0] exp_wim;
        int          exp_lat;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 5'd0, 32'h0000_1000, 0, 5'd2, 32'h2, 36};
        tbl[1] = '{1'b0, 1'b1, 5'd2, 32'h0000_2000, 3, 5'd0, 32'h2, FILL_EN ? 84 : 4};
        tbl[2] = '{1'b1, 1'b0, 5'd1, 32'h0000_0040, 0, 5'd0, 32'h4, 36};
        tbl[3] = '{1'b1, 1'b0, 5'd2, 32'h0000_0080, 1, 5'd1, 32'h1, 52};
        tbl[4] = '{1'b0, 1'b1, 5'd0, 32'h0000_0100, 0, 5'd1, 32'h4, FILL_EN ? 36 : 4};
        tbl[5] = '{1'b0, 1'b1, 5'd1, 32'h0000_0200, 2, 5'd2, 32'h1, FILL_EN ? 68 : 4};
        tbl[6] = '{1'b1, 1'b0, 5'd0, 32'hFFFF_FFF8, 0, 5'd2, 32'h2, 36};

        rst = 1'b0;
        windows_overflow = 1'b0; windows_underflow = 1'b0;
        cwp = 5'd0; save_base = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", any_out, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Spurious acknowledges while idle
        clear_mon();
        spur = 1'b1;
        repeat (10) @(negedge clk);
        spur = 1'b0;
        chk("idle_spur_no_start", rise_q.size(), 0);
        chk("idle_spur_busy", busy, 1'b0);

        for (int t = 0; t < 7; t++) begin
            run_trap(tbl[t].ov, tbl[t].un, tbl[t].cwp, tbl[t].base, tbl[t].waits, 1'b0);
            $display("vec %0d ov=%0d un=%0d cwp=%0d base=%h waits=%0d handled=%0d",
                     t, tbl[t].ov, tbl[t].un, tbl[t].cwp, tbl[t].base, tbl[t].waits, h_cyc_q.size());
            chk($sformatf("tbl%0d_w", t), (cwp_q.size() > 0) ? cwp_q[0] : 5'bx, tbl[t].exp_w);
            chk($sformatf("tbl%0d_wim", t), (wim_q.size() > 0) ? wim_q[0] : 32'bx, tbl[t].exp_wim);
            chk($sformatf("tbl%0d_lat", t),
                (h_cyc_q.size() > 0 && rise_q.size() > 0) ? h_cyc_q[0] - rise_q[0] + 1 : -1,
                tbl[t].exp_lat);
            verify(tbl[t].ov, tbl[t].cwp, tbl[t].base, tbl[t].waits);
        end

        for (int t = 0; t < 24; t++) begin
            bit          ov, un, sp;
            logic [4:0]  c;
            logic [31:0] b;
            int          w;
            ov = 1'($urandom_range(0, 1));
            un = ov ? 1'($urandom_range(0, 1)) : 1'b1;
            c  = 5'($urandom_range(0, N - 1));
            b  = $urandom;
            w  = $urandom_range(0, 2);
            sp = 1'($urandom_range(0, 1));
            run_trap(ov, un, c, b, w, sp);
            $display("rnd %0d ov=%0d un=%0d cwp=%0d base=%h waits=%0d spur=%0d", t, ov, un, c, b, w, sp);
            verify(ov, c, b, w);
        end

        // Simultaneous traps: spill first, fill starts right after DONE
        waits = 0;
        @(negedge clk);
        clear_mon();
        windows_overflow = 1'b1; windows_underflow = 1'b1; cwp = 5'd0; save_base = 32'h5000;
        @(negedge clk);
        windows_overflow = 1'b0;
        wait_q(0, 1, "both_first_handled");
        wait_q(1, 2, "both_second_start");
        windows_underflow = 1'b0;
        wait_q(0, 2, "both_second_handled");
        repeat (4) @(negedge clk);
        $display("both: handled=%0d starts=%0d", h_kind_q.size(), rise_q.size());
        chk("both_count", h_kind_q.size(), 2);
        chk("both_first_spill", (h_kind_q.size() > 0) ? h_kind_q[0] : 1'bx, 1'b1);
        chk("both_second_fill", (h_kind_q.size() > 1) ? h_kind_q[1] : 1'bx, 1'b0);
        chk("both_restart_gap", (rise_q.size() > 1 && h_cyc_q.size() > 0) ? rise_q[1] - h_cyc_q[0] : -1, 2);
        chk("both_starts", rise_q.size(), 2);

        // Reset in the middle of the eighth spill write
        waits = 4;
        @(negedge clk);
        clear_mon();
        windows_overflow = 1'b1; cwp = 5'd1; save_base = 32'h3000;
        @(negedge clk);
        windows_overflow = 1'b0;
        wait_q(2, 7, "rst_reach_idx7");
        begin
            int k = 0;
            while (!(mem_req && mem_addr == 32'h301C) && k < 50) begin
                @(negedge clk);
                k++;
            end
            chk("rst_in_sp_wr_idx7", mem_req && mem_addr == 32'h301C, 1'b1);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("rst mid-spill: busy=%0d any_out=%0d", busy, any_out);
        chk("rst_outputs_zero", any_out, 1'b0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_no_handled", h_kind_q.size(), 0);
        chk("rst_no_cwp_restore", cwp_q.size(), 1);
        chk("rst_idle", busy, 1'b0);
        waits = 0;

        chk("strobe_exclusive", viol_excl, 0);
        chk("idle_quiet", viol_idle, 0);
        chk("mem_req_stable", viol_stab, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
